// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access size codes,
// controller states and the beat-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    CNF_NONE = 2'd0,
    CNF_B    = 2'd1,
    CNF_H    = 2'd2,
    CNF_W    = 2'd3
  } cnf_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_e;

  // Instruction fetches are always full 32-bit words.
  localparam logic [1:0] FETCH_LAST_BEAT = 2'd3;

  // Index of the final byte beat for a data access of the given size.
  function automatic logic [1:0] last_beat(input logic [1:0] cnf);
    case (cnf)
      CNF_B:   return 2'd0;
      CNF_H:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller between the core (fetch + MEM-stage ports) and an
// 8-bit RAM; data port has priority, words are assembled little-endian.
import mem_ctrl_pkg::*;

module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_inst,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic              wr_mem,
  input  logic [31:0]       data_mem,
  input  logic [1:0]        cnf_mem,
  output logic              addr_needed,
  output logic              mem_working,
  output logic              mem_available,
  output logic [31:0]       data_in,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("mem_ctrl only supports RD_LAT == 1");
  end

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_available_q, mem_available_d;
  logic              if_ready_q, if_ready_d;
  logic              cap_valid_q, cap_valid_d;
  logic              cap_fetch_q, cap_fetch_d;
  logic [1:0]        cap_idx_q, cap_idx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       inst_q, inst_d;

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    last_d          = last_q;
    base_d          = base_q;
    wr_d            = wr_q;
    wdata_d         = wdata_q;
    mem_available_d = 1'b0;
    if_ready_d      = 1'b0;
    cap_valid_d     = 1'b0;
    cap_fetch_d     = 1'b0;
    cap_idx_d       = k_q;
    data_d          = data_q;
    inst_d          = inst_q;

    // The byte addressed last cycle arrives now; a new accept below clears the word afterwards.
    if (cap_valid_q) begin
      if (cap_fetch_q) inst_d[{cap_idx_q, 3'b000} +: 8] = ram_din;
      else             data_d[{cap_idx_q, 3'b000} +: 8] = ram_din;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cnf_mem != CNF_NONE) begin
          state_d = ST_DATA;
          k_d     = 2'd0;
          last_d  = last_beat(cnf_mem);
          base_d  = addr_mem;
          wr_d    = wr_mem;
          wdata_d = data_mem;
          data_d  = '0;
        end else if (if_req && !if_flush) begin
          state_d = ST_FETCH;
          k_d     = 2'd0;
          last_d  = FETCH_LAST_BEAT;
          base_d  = if_addr;
          wr_d    = 1'b0;
          inst_d  = '0;
        end
      end
      ST_DATA: begin
        cap_valid_d = !wr_q;
        if (k_q == last_q) begin
          state_d         = ST_IDLE;
          mem_available_d = 1'b1;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_FETCH: begin
        if (if_flush) begin
          state_d = ST_IDLE;
        end else begin
          cap_valid_d = 1'b1;
          cap_fetch_d = 1'b1;
          if (k_q == last_q) begin
            state_d    = ST_IDLE;
            if_ready_d = 1'b1;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      k_q             <= '0;
      last_q          <= '0;
      base_q          <= '0;
      wr_q            <= 1'b0;
      wdata_q         <= '0;
      mem_available_q <= 1'b0;
      if_ready_q      <= 1'b0;
      cap_valid_q     <= 1'b0;
      cap_fetch_q     <= 1'b0;
      cap_idx_q       <= '0;
      data_q          <= '0;
      inst_q          <= '0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      last_q          <= last_d;
      base_q          <= base_d;
      wr_q            <= wr_d;
      wdata_q         <= wdata_d;
      mem_available_q <= mem_available_d;
      if_ready_q      <= if_ready_d;
      cap_valid_q     <= cap_valid_d;
      cap_fetch_q     <= cap_fetch_d;
      cap_idx_q       <= cap_idx_d;
      data_q          <= data_d;
      inst_q          <= inst_d;
    end
  end

  // Pulse cycles are IDLE cycles, so no beat is driven while a completion is reported.
  assign ram_a         = (state_q != ST_IDLE) ? base_q + ADDR_W'(k_q) : '0;
  assign ram_wr        = (state_q == ST_DATA) && wr_q;
  assign ram_dout      = ((state_q == ST_DATA) && wr_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;
  assign mem_working   = (state_q == ST_DATA);
  assign addr_needed   = (state_q == ST_IDLE) && rst;
  assign mem_available = mem_available_q;
  assign if_ready      = if_ready_q;

  // The final byte only reaches the RAM data pins in the pulse cycle; forward it so the word is complete there.
  always_comb begin
    data_in = data_q;
    if_inst = inst_q;
    if (cap_valid_q) begin
      if (cap_fetch_q) if_inst[{cap_idx_q, 3'b000} +: 8] = ram_din;
      else             data_in[{cap_idx_q, 3'b000} +: 8] = ram_din;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM model plus an address-indexed
// reference memory predicting load words, beat addresses and completion timing.
module tb_mem_ctrl;

  logic        clk, rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_inst;
  logic [31:0] addr_mem, data_mem, data_in, ram_a;
  logic        wr_mem, addr_needed, mem_working, mem_available, ram_wr;
  logic [1:0]  cnf_mem;
  logic [7:0]  ram_dout, ram_din;

  int n_cmp = 0;
  int n_bad = 0;

  mem_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_inst(if_inst),
    .addr_mem(addr_mem), .wr_mem(wr_mem), .data_mem(data_mem), .cnf_mem(cnf_mem),
    .addr_needed(addr_needed), .mem_working(mem_working), .mem_available(mem_available),
    .data_in(data_in),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 64 KiB window (low 16 address bits), unwritten bytes read a fixed pattern.
  bit [7:0] ram_mem [0:65535];
  bit       ram_set [0:65535];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_peek(input logic [31:0] a);
    return ram_set[a[15:0]] ? ram_mem[a[15:0]] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (ram_wr === 1'b1) begin
      ram_mem[ram_a[15:0]] <= ram_dout;
      ram_set[ram_a[15:0]] <= 1'b1;
    end
    ram_din <= ram_peek(ram_a);
  end

  // Reference memory: what every byte should hold after the stores issued so far.
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic int nbytes(input logic [1:0] c);
    return (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data transaction, accepted at the next edge; returns in the completion-pulse cycle.
  task automatic do_data(input logic w, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] wd, input string name);
    int n;
    logic [31:0] ea;
    logic [31:0] exp;
    n = nbytes(c);
    exp = '0;
    for (int i = 0; i < n; i++) begin
      ea = a + 32'(i);
      if (w) ref_mem[ea] = wd[8*i +: 8];
      else   exp[8*i +: 8] = ref_rd(ea);
    end
    n_cmp++; if (addr_needed !== 1'b1) begin n_bad++; $display("FAIL %s addr_needed before accept: got %b expected 1", name, addr_needed); end
    addr_mem = a; wr_mem = w; data_mem = wd; cnf_mem = c;
    tick();
    for (int i = 0; i < n; i++) begin
      addr_mem = $urandom; data_mem = $urandom; wr_mem = 1'($urandom); cnf_mem = 2'($urandom);
      ea = a + 32'(i);
      n_cmp++; if (mem_available !== 1'b0) begin n_bad++; $display("FAIL %s early mem_available beat %0d: got %b expected 0", name, i, mem_available); end
      n_cmp++; if (mem_working !== 1'b1) begin n_bad++; $display("FAIL %s mem_working beat %0d: got %b expected 1", name, i, mem_working); end
      n_cmp++; if (addr_needed !== 1'b0) begin n_bad++; $display("FAIL %s addr_needed beat %0d: got %b expected 0", name, i, addr_needed); end
      n_cmp++; if (ram_a !== ea) begin n_bad++; $display("FAIL %s ram_a beat %0d: got %h expected %h", name, i, ram_a, ea); end
      n_cmp++; if (ram_wr !== w) begin n_bad++; $display("FAIL %s ram_wr beat %0d: got %b expected %b", name, i, ram_wr, w); end
      if (w) begin
        n_cmp++; if (ram_dout !== wd[8*i +: 8]) begin n_bad++; $display("FAIL %s ram_dout beat %0d: got %h expected %h", name, i, ram_dout, wd[8*i +: 8]); end
      end
      tick();
    end
    cnf_mem = 2'd0; wr_mem = 1'b0;
    n_cmp++; if (mem_available !== 1'b1) begin n_bad++; $display("FAIL %s mem_available at n+1: got %b expected 1", name, mem_available); end
    n_cmp++; if (mem_working !== 1'b0) begin n_bad++; $display("FAIL %s mem_working in pulse: got %b expected 0", name, mem_working); end
    n_cmp++; if (addr_needed !== 1'b1) begin n_bad++; $display("FAIL %s addr_needed in pulse: got %b expected 1", name, addr_needed); end
    n_cmp++; if (ram_wr !== 1'b0 || ram_a !== 32'h0) begin n_bad++; $display("FAIL %s idle ram bus in pulse: got wr=%b a=%h expected wr=0 a=0", name, ram_wr, ram_a); end
    if (!w) begin
      n_cmp++; if (data_in !== exp) begin n_bad++; $display("FAIL %s data_in: got %h expected %h", name, data_in, exp); end
    end
    $display("data %-10s %s cnf=%0d addr=%h wdata=%h rdata=%h", name, w ? "st" : "ld", c, a, wd, data_in);
  endtask

  // One fetch, accepted at the next edge; returns in the if_ready cycle with if_req dropped.
  task automatic do_fetch(input logic [31:0] a, input string name);
    logic [31:0] exp;
    logic [31:0] ea;
    for (int i = 0; i < 4; i++) exp[8*i +: 8] = ref_rd(a + 32'(i));
    n_cmp++; if (addr_needed !== 1'b1) begin n_bad++; $display("FAIL %s addr_needed before fetch: got %b expected 1", name, addr_needed); end
    if_req = 1'b1; if_addr = a; if_flush = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if_addr = $urandom;
      ea = a + 32'(i);
      n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL %s early if_ready beat %0d: got %b expected 0", name, i, if_ready); end
      n_cmp++; if (mem_working !== 1'b0 || addr_needed !== 1'b0) begin n_bad++; $display("FAIL %s status beat %0d: got working=%b needed=%b expected 0/0", name, i, mem_working, addr_needed); end
      n_cmp++; if (ram_a !== ea || ram_wr !== 1'b0) begin n_bad++; $display("FAIL %s ram bus beat %0d: got a=%h wr=%b expected a=%h wr=0", name, i, ram_a, ram_wr, ea); end
      tick();
    end
    if_req = 1'b0;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL %s if_ready at 5: got %b expected 1", name, if_ready); end
    n_cmp++; if (if_inst !== exp) begin n_bad++; $display("FAIL %s if_inst: got %h expected %h", name, if_inst, exp); end
    n_cmp++; if (addr_needed !== 1'b1) begin n_bad++; $display("FAIL %s addr_needed in ready cycle: got %b expected 1", name, addr_needed); end
    $display("fetch %-10s addr=%h inst=%h", name, a, if_inst);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    addr_mem = '0; wr_mem = 1'b0; data_mem = '0; cnf_mem = 2'd0;
    repeat (3) tick();
    n_cmp++; if (addr_needed !== 1'b0) begin n_bad++; $display("FAIL reset addr_needed: got %b expected 0", addr_needed); end
    n_cmp++; if ({mem_working, mem_available, if_ready, ram_wr} !== 4'b0) begin n_bad++; $display("FAIL reset flags: got %b expected 0000", {mem_working, mem_available, if_ready, ram_wr}); end
    n_cmp++; if (ram_a !== 32'h0 || ram_dout !== 8'h0) begin n_bad++; $display("FAIL reset ram bus: got a=%h dout=%h expected 0/0", ram_a, ram_dout); end
    n_cmp++; if (data_in !== 32'h0 || if_inst !== 32'h0) begin n_bad++; $display("FAIL reset words: got data_in=%h if_inst=%h expected 0/0", data_in, if_inst); end
    rst = 1'b1;
    #1;
    n_cmp++; if (addr_needed !== 1'b1) begin n_bad++; $display("FAIL reset release addr_needed: got %b expected 1", addr_needed); end
    tick();
    $display("reset released");
  endtask

  task automatic test_lw();
    do_data(1'b1, 2'd3, 32'h100, 32'h44332211, "sw_100");
    tick();
    do_data(1'b0, 2'd3, 32'h100, 32'h0, "lw_100");
    n_cmp++; if (data_in !== 32'h44332211) begin n_bad++; $display("FAIL lw_100 word: got %h expected 44332211", data_in); end
    tick(); tick();
    n_cmp++; if (data_in !== 32'h44332211) begin n_bad++; $display("FAIL lw_100 hold: got %h expected 44332211", data_in); end
  endtask

  task automatic test_sb();
    logic [7:0] nb;
    nb = ref_rd(32'h201);
    do_data(1'b1, 2'd1, 32'h200, 32'hDEADBEEF, "sb_200");
    tick();
    n_cmp++; if (ram_peek(32'h200) !== 8'hEF) begin n_bad++; $display("FAIL sb_200 ram byte: got %h expected ef", ram_peek(32'h200)); end
    n_cmp++; if (ram_peek(32'h201) !== nb) begin n_bad++; $display("FAIL sb_200 neighbour: got %h expected %h", ram_peek(32'h201), nb); end
    do_data(1'b0, 2'd1, 32'h200, 32'h0, "lb_200");
    tick();
  endtask

  task automatic test_wrap();
    do_data(1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_1234, "sh_wrap");
    tick();
    n_cmp++; if (ram_peek(32'hFFFF_FFFF) !== 8'h34 || ram_peek(32'h0) !== 8'h12) begin n_bad++; $display("FAIL sh_wrap bytes: got %h %h expected 34 12", ram_peek(32'hFFFF_FFFF), ram_peek(32'h0)); end
    do_data(1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0, "lh_wrap");
    n_cmp++; if (data_in !== 32'h0000_1234) begin n_bad++; $display("FAIL lh_wrap word: got %h expected 00001234", data_in); end
    tick();
  endtask

  task automatic test_arbitration();
    if_req = 1'b1; if_addr = 32'h0;
    do_data(1'b0, 2'd3, 32'h0, 32'h0, "arb_lw");
    do_fetch(32'h0, "arb_if");
    tick();
  endtask

  task automatic test_data_waits();
    logic [31:0] ea;
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    addr_mem = 32'h700; wr_mem = 1'b0; cnf_mem = 2'd1;
    for (int i = 0; i < 4; i++) begin
      ea = 32'h40 + 32'(i);
      n_cmp++; if (mem_working !== 1'b0 || ram_a !== ea) begin n_bad++; $display("FAIL wait beat %0d: got working=%b a=%h expected 0 %h", i, mem_working, ram_a, ea); end
      tick();
    end
    if_req = 1'b0;
    n_cmp++; if (if_ready !== 1'b1 || addr_needed !== 1'b1) begin n_bad++; $display("FAIL wait end: got ready=%b needed=%b expected 1/1", if_ready, addr_needed); end
    $display("fetch wait_if    addr=00000040 inst=%h", if_inst);
    do_data(1'b0, 2'd1, 32'h700, 32'h0, "wait_lb");
    tick();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) if_flush = 1'b1;
      n_cmp++; if (ram_a !== 32'h40 + 32'(i) || if_ready !== 1'b0) begin n_bad++; $display("FAIL flush beat %0d: got a=%h ready=%b expected %h 0", i, ram_a, if_ready, 32'h40 + 32'(i)); end
      tick();
    end
    if_flush = 1'b0;
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL flush if_ready: got %b expected 0", if_ready); end
    n_cmp++; if (addr_needed !== 1'b1 || ram_a !== 32'h0) begin n_bad++; $display("FAIL flush idle: got needed=%b a=%h expected 1 0", addr_needed, ram_a); end
    $display("fetch flushed    addr=00000040");
    do_fetch(32'h80, "after_fl");
    tick();
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h44;
    tick();
    n_cmp++; if (addr_needed !== 1'b1 || ram_a !== 32'h0) begin n_bad++; $display("FAIL idle flush accepted: got needed=%b a=%h expected 1 0", addr_needed, ram_a); end
    if_req = 1'b0; if_flush = 1'b0;
    $display("fetch refused    addr=00000044 (flush in idle)");
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = 32'hA1B2C3D4;
    do_data(1'b0, 2'd3, 32'h300, 32'h0, "pre_rst");
    tick();
    addr_mem = 32'h300; wr_mem = 1'b1; data_mem = d; cnf_mem = 2'd3;
    tick();
    cnf_mem = 2'd0; wr_mem = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (ram_wr !== 1'b0 || mem_working !== 1'b0 || mem_available !== 1'b0) begin n_bad++; $display("FAIL rst_mid outputs: got wr=%b working=%b avail=%b expected 0 0 0", ram_wr, mem_working, mem_available); end
    n_cmp++; if (data_in !== 32'h0) begin n_bad++; $display("FAIL rst_mid data_in: got %h expected 0", data_in); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (mem_available !== 1'b0) begin n_bad++; $display("FAIL rst_mid late pulse %0d: got %b expected 0", i, mem_available); end
    end
    ref_mem[32'h300] = d[7:0];
    ref_mem[32'h301] = d[15:8];
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ram_peek(32'h300 + 32'(i)) !== ref_rd(32'h300 + 32'(i))) begin n_bad++; $display("FAIL rst_mid byte %0d: got %h expected %h", i, ram_peek(32'h300 + 32'(i)), ref_rd(32'h300 + 32'(i))); end
    end
    $display("data rst_mid     st cnf=3 addr=00000300 aborted after 2 beats");
    do_data(1'b0, 2'd3, 32'h300, 32'h0, "post_rst");
    tick();
  endtask

  task automatic test_back_to_back();
    do_data(1'b1, 2'd3, 32'h500, $urandom, "b2b_sw");
    do_data(1'b0, 2'd3, 32'h500, 32'h0, "b2b_lw");
    do_fetch(32'h500, "b2b_if");
    do_data(1'b0, 2'd1, 32'h502, 32'h0, "b2b_lb");
    tick();
  endtask

  task automatic test_random();
    int op;
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 6);
      if (op == 6) do_fetch(32'($urandom_range(0, 4095)), "rnd_if");
      else do_data(1'(op), 2'($urandom_range(1, 3)), 32'($urandom_range(0, 4095)), $urandom, "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    foreach (ref_mem[k]) begin
      n_cmp++; if (ram_peek(k) !== ref_mem[k]) begin n_bad++; $display("FAIL ram content %h: got %h expected %h", k, ram_peek(k), ref_mem[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_wrap();
    test_arbitration();
    test_data_waits();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
